btn_debounce: RTL
=================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, is the system clock frequency in Hz.
REQ-002 Parameter N_BTN, default 2, is the number of independent button channels (1..8).
REQ-003 Parameter DEBOUNCE_MS, default 20, is the stability window in ms; DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS, and elaboration SHALL fail if DB_CYCLES < 2.
REQ-004 Parameter LONG_MS, default 1000, is the long-press threshold in ms; LONG_CYCLES = CLK_HZ/1000*LONG_MS, and elaboration SHALL fail if LONG_CYCLES <= DB_CYCLES.
REQ-005 clk  input  1  is the single system clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  is a synchronous, active-high reset.
REQ-007 btn_raw  input  N_BTN  is the asynchronous, bouncing button level per channel (1 = pressed).
REQ-008 btn_level  output  N_BTN  is the debounced, registered level per channel.
REQ-009 btn_press  output  N_BTN  is a one-cycle pulse on each debounced 0->1 transition.
REQ-010 btn_release  output  N_BTN  is a one-cycle pulse on each debounced 1->0 transition.
REQ-011 btn_long  output  N_BTN  is a one-cycle long-press pulse; it is present only when the macro in REQ-030 is defined.

Function
REQ-012 Each channel SHALL pass btn_raw through a 2-flop synchronizer before any other logic uses it; sync[i] is the second flop output.
REQ-013 Each channel SHALL run an independent FSM with states RELEASED, PRESS_PEND, HELD and RELEASE_PEND, plus a debounce counter of width $clog2(DB_CYCLES+1).
REQ-014 In RELEASED with sync=1, the FSM SHALL go to PRESS_PEND and load the counter with 1; with sync=0 it SHALL stay in RELEASED.
REQ-015 In PRESS_PEND with sync=0 (a glitch), the FSM SHALL return to RELEASED and clear the counter, with no output change.
REQ-016 In PRESS_PEND with sync=1 and counter < DB_CYCLES-1, the counter SHALL increment.
REQ-017 In PRESS_PEND with sync=1 and counter = DB_CYCLES-1, the FSM SHALL go to HELD, set btn_level=1, pulse btn_press for exactly one cycle and clear the counter.
REQ-018 HELD and RELEASE_PEND SHALL mirror REQ-014 to REQ-017 with sync=0 as the pending condition; on acceptance the FSM SHALL return to RELEASED, clear btn_level and pulse btn_release.
REQ-019 A stable raw change SHALL be reflected on btn_level exactly DB_CYCLES+2 clock edges after the first edge that samples the new raw value (2 synchronizer edges plus DB_CYCLES stability edges).
REQ-020 btn_press and btn_release SHALL assert in the same cycle that btn_level first shows its new value, and SHALL never be high in the same cycle on the same channel.
REQ-021 Any bounce shorter than DB_CYCLES consecutive synchronized samples SHALL produce no change on btn_level and no pulse.
REQ-022 Channels SHALL be fully independent; simultaneous events on different channels SHALL each produce their own pulses in the same cycle.
REQ-023 All outputs SHALL be driven directly from flops, with no combinational path from btn_raw to any output.

Reset
REQ-024 While rst=1, every synchronizer flop, counter and output SHALL be 0 and every FSM SHALL be in RELEASED.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL abandon the operation with no release pulse; after rst deasserts, btn_level SHALL be 0.
REQ-026 If btn_raw is held at 1 through reset, it SHALL be treated as a new press and btn_press SHALL pulse DB_CYCLES+2 edges after rst deasserts.

Configuration
REQ-027 With the macro defined, each channel SHALL also have a hold counter of width $clog2(LONG_CYCLES+1).
REQ-028 With the macro defined, the hold counter SHALL count cycles while in HELD or RELEASE_PEND; when it reaches LONG_CYCLES-1 it SHALL pulse btn_long once, saturate, and re-arm only after a debounced release.
REQ-029 With the macro defined, a glitch in RELEASE_PEND SHALL not reset the hold counter.
REQ-030 The macro BTN_LONG_PRESS_EN SHALL gate the long-press feature; when it is not defined, the port btn_long SHALL still exist, be tied to 0, and no hold-counter logic SHALL be synthesized.

Verification (CLK_HZ=1000, DEBOUNCE_MS=4 so DB_CYCLES=4, LONG_MS=10 so LONG_CYCLES=10, N_BTN=2)
REQ-031 Clean press on channel 0 at edge 0, held -> btn_level[0] rises and btn_press[0] pulses for 1 cycle after edge 5; no activity on channel 1.
REQ-032 Bounce 1,0,1,0 toggled every cycle, then a stable 1 -> exactly one btn_press pulse, 6 edges after the stable 1 begins; btn_release stays 0 throughout.
REQ-033 Press both channels on the same edge, then release channel 1 only after 8 cycles -> both press pulses coincide; btn_release[1] pulses alone 6 edges after the release.
REQ-034 rst=1 for 1 cycle while channel 0 is HELD with raw still 1 -> outputs read 0 during reset, no release pulse, and btn_press[0] pulses again 6 edges after rst deasserts.
REQ-035 With BTN_LONG_PRESS_EN defined, hold for 20 cycles -> exactly one btn_long[0] pulse, 10 cycles after btn_press[0]; without the macro, btn_long stays 0.
REQ-036 A 3-cycle low glitch while HELD -> btn_level remains 1 with no pulses, and btn_long timing is unaffected.

Source files
------------

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer: 2-flop synchronizer, per-channel debounce FSM, press/release pulses.
// Optional long-press pulse on btn_long when BTN_LONG_PRESS_EN is defined (otherwise tied to 0).
module btn_debounce #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned N_BTN       = 2,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    localparam int unsigned DB_CYCLES   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int unsigned LONG_CYCLES = CLK_HZ / 1000 * LONG_MS;
    localparam int unsigned CNT_W       = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 2) begin : g_bad_db
        $error("btn_debounce: DB_CYCLES must be at least 2");
    end
    if (LONG_CYCLES <= DB_CYCLES) begin : g_bad_long
        $error("btn_debounce: LONG_CYCLES must exceed DB_CYCLES");
    end
    if (N_BTN < 1 || N_BTN > 8) begin : g_bad_nbtn
        $error("btn_debounce: N_BTN must be in 1..8");
    end

    typedef enum logic [1:0] {
        StReleased,
        StPressPend,
        StHeld,
        StReleasePend
    } state_e;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level_q;
        logic             press_q;
        logic             release_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= StReleased;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                unique case (state_q)
                    StReleased: begin
                        if (sync2[i]) begin
                            state_q <= StPressPend;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    StPressPend: begin
                        if (!sync2[i]) begin
                            state_q <= StReleased;
                            cnt_q   <= '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_q <= StHeld;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StHeld: begin
                        if (!sync2[i]) begin
                            state_q <= StReleasePend;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    StReleasePend: begin
                        if (sync2[i]) begin
                            state_q <= StHeld;
                            cnt_q   <= '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_q   <= StReleased;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StReleased;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;

`ifdef BTN_LONG_PRESS_EN
        localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
        localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
        localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

        logic [HOLD_W-1:0] hold_q;
        logic              long_q;
        logic              releasing;
        logic              holding;

        assign releasing = (state_q == StReleasePend) && !sync2[i] && (cnt_q == DB_LAST);
        assign holding   = (state_q == StHeld) || (state_q == StReleasePend);

        // Saturating at LONG_CYCLES keeps the pulse single until a debounced release clears it.
        always_ff @(posedge clk) begin
            if (rst) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (releasing) begin
                    hold_q <= '0;
                end else if (holding && hold_q == HOLD_LAST) begin
                    long_q <= 1'b1;
                    hold_q <= HOLD_SAT;
                end else if (holding && hold_q != HOLD_SAT) begin
                    hold_q <= hold_q + 1'b1;
                end
            end
        end

        assign btn_long[i] = long_q;
`else
        assign btn_long[i] = 1'b0;
`endif
    end

endmodule
